// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_pkg
// Purpose  : Shared types, defaults and parity helper for the TDM demux.
// Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_SLOTS = 8;
    localparam int PAR_MAX_W     = 64;

    // Even parity of a zero-extended word (supports SLOTS up to PAR_MAX_W).
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_demux_8.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_8
// Purpose  : Serial TDM stream to parallel word reassembly with frame lock.
//            Optional trailing parity beat enabled by TDM_DEMUX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_8
    import tdm_pkg::*;
#(
    parameter int SLOTS = DEFAULT_SLOTS,
`ifdef TDM_DEMUX_PARITY_EN
    parameter int SEL_W = $clog2(SLOTS + 1)
`else
    parameter int SEL_W = $clog2(SLOTS)
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_sync,
    output logic [SLOTS-1:0] out,
    output logic             out_valid,
    output logic [SEL_W-1:0] sel,
    output logic             sync_err,
    output logic             par_err
);

    localparam int               IDX_W     = $clog2(SLOTS);
    localparam logic [SEL_W-1:0] LAST_DATA = SEL_W'(SLOTS - 1);
    localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);
`ifdef TDM_DEMUX_PARITY_EN
    localparam logic [SEL_W-1:0] PAR_SEL   = SEL_W'(SLOTS);
`endif

    state_t           state;
    logic [SLOTS-1:0] shadow;
    logic [SLOTS-1:0] frame_word;
    logic [IDX_W-1:0] idx;

    // Shadow with the current beat merged in; on the last data slot this is
    // exactly the completed frame.
    always_comb begin
        idx                  = sel[IDX_W-1:0];
        frame_word           = shadow;
        frame_word[idx]      = in_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            sel       <= '0;
            sync_err  <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            par_err   <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (in_sync) begin
                            shadow[0] <= in_bit;
                            sel       <= SEL_ONE;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        if (in_sync && (sel != '0)) begin
                            // Misaligned sync: drop partial frame, restart at slot 0.
                            sync_err  <= 1'b1;
                            shadow[0] <= in_bit;
                            sel       <= SEL_ONE;
`ifdef TDM_DEMUX_PARITY_EN
                        end else if (sel == PAR_SEL) begin
                            if (in_bit == even_parity(PAR_MAX_W'(shadow))) begin
                                out       <= shadow;
                                out_valid <= 1'b1;
                            end else begin
                                par_err   <= 1'b1;
                            end
                            sel <= '0;
`else
                        end else if (sel == LAST_DATA) begin
                            out       <= frame_word;
                            out_valid <= 1'b1;
                            sel       <= '0;
`endif
                        end else begin
                            shadow[idx] <= in_bit;
                            sel         <= sel + SEL_ONE;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        sel   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux_8
// Purpose  : Self-checking bench for tdm_demux_8 (frame-level model + literals).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_8;
    import tdm_pkg::*;

    localparam int SLOTS = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SEL_W = $clog2(SLOTS + 1);
    localparam int FRAME = SLOTS + 1;
`else
    localparam int SEL_W = $clog2(SLOTS);
    localparam int FRAME = SLOTS;
`endif

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit   = 1'b0;
    logic             in_sync  = 1'b0;
    logic [SLOTS-1:0] out;
    logic             out_valid;
    logic [SEL_W-1:0] sel;
    logic             sync_err;
    logic             par_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdm_demux_8 #(.SLOTS(SLOTS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_sync   (in_sync),
        .out       (out),
        .out_valid (out_valid),
        .sel       (sel),
        .sync_err  (sync_err),
        .par_err   (par_err)
    );

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a locked stream collects beats into a list; a full
    // list becomes a word (plus optional parity check).
    bit   m_locked = 1'b0;
    logic m_bits[$];
    int   m_out    = 0;
    bit   m_ov     = 1'b0;
    bit   m_se     = 1'b0;
    bit   m_pe     = 1'b0;

    always @(posedge clk) begin
        int  word;
        bit  ok;
        m_ov = 1'b0;
        m_se = 1'b0;
        m_pe = 1'b0;
        if (!rst_n) begin
            m_locked = 1'b0;
            m_bits.delete();
            m_out = 0;
        end else if (in_valid) begin
            if (in_sync) begin
                if (m_locked && m_bits.size() != 0) m_se = 1'b1;
                m_bits.delete();
                m_locked = 1'b1;
            end
            if (m_locked) begin
                m_bits.push_back(in_bit);
                if (m_bits.size() == FRAME) begin
                    word = 0;
                    for (int k = 0; k < SLOTS; k++) word = word + (int'(m_bits[k]) << k);
                    ok = 1'b1;
                    if (FRAME > SLOTS) ok = (int'(m_bits[FRAME-1]) == ($countones(word) % 2));
                    if (ok) begin
                        m_out = word;
                        m_ov  = 1'b1;
                    end else begin
                        m_pe = 1'b1;
                    end
                    m_bits.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        cmp("cyc_out",       int'(out),       m_out);
        cmp("cyc_out_valid", int'(out_valid), int'(m_ov));
        cmp("cyc_sel",       int'(sel),       m_bits.size());
        cmp("cyc_sync_err",  int'(sync_err),  int'(m_se));
        cmp("cyc_par_err",   int'(par_err),   int'(m_pe));
    end

    task automatic beat(input logic v, input logic s, input logic b);
        @(posedge clk);
        #2;
        in_valid = v;
        in_sync  = s;
        in_bit   = b;
    endtask

    // Let the last driven beat be accepted, idle the link, sample its result.
    task automatic settle();
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] w, input int from, input bit with_sync,
                             input bit par_flip);
        for (int k = from; k < SLOTS; k++) beat(1'b1, with_sync && (k == 0), w[k]);
`ifdef TDM_DEMUX_PARITY_EN
        beat(1'b1, 1'b0, (^w) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored without parity beat");
`endif
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] w;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        cmp("rst_out", int'(out), 0);
        cmp("rst_sel", int'(sel), 0);
        cmp("rst_out_valid", int'(out_valid), 0);

        // 1,0,1,1,0,0,1,0 in slots 0..7
        send_bits(8'h4D, 0, 1'b1, 1'b0);
        settle();
        cmp("f4d_out", int'(out), 'h4D);
        cmp("f4d_valid", int'(out_valid), 1);
        @(negedge clk);
        cmp("f4d_valid_pulse", int'(out_valid), 0);

        // Unsynced beats after reset are ignored
        reset_pulse();
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b1);
        settle();
        cmp("hunt_sel", int'(sel), 0);
        cmp("hunt_valid", int'(out_valid), 0);
        send_bits(8'hFF, 0, 1'b1, 1'b0);
        settle();
        cmp("fff_out", int'(out), 'hFF);

        // Three idle cycles between slots 3 and 4
        w = 8'hA5;
        for (int k = 0; k < 4; k++) beat(1'b1, k == 0, w[k]);
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 1'b1);
        send_bits(w, 4, 1'b0, 1'b0);
        settle();
        cmp("fa5_out", int'(out), 'hA5);
        cmp("fa5_sync_err", int'(sync_err), 0);

        // Sync landing at slot 5 restarts the frame
        for (int k = 0; k < 5; k++) beat(1'b1, k == 0, 1'b1);
        beat(1'b1, 1'b1, 1'b0);
        settle();
        cmp("serr_pulse", int'(sync_err), 1);
        cmp("serr_out_held", int'(out), 'hA5);
        cmp("serr_sel", int'(sel), 1);
        send_bits(8'h3C, 1, 1'b0, 1'b0);
        settle();
        cmp("f3c_out", int'(out), 'h3C);

        // Reset in the middle of a frame
        for (int k = 0; k < 4; k++) beat(1'b1, k == 0, 1'b1);
        settle();
        cmp("pre_rst_sel", int'(sel), 4);
        reset_pulse();
        cmp("mid_rst_out", int'(out), 0);
        cmp("mid_rst_sel", int'(sel), 0);
        send_bits(8'h81, 0, 1'b1, 1'b0);
        settle();
        cmp("f81_out", int'(out), 'h81);

`ifdef TDM_DEMUX_PARITY_EN
        send_bits(8'h4D, 0, 1'b1, 1'b0);
        settle();
        cmp("par_ok_out", int'(out), 'h4D);
        send_bits(8'h81, 0, 1'b0, 1'b1);
        settle();
        cmp("par_bad_err", int'(par_err), 1);
        cmp("par_bad_out", int'(out), 'h4D);
`endif

        // Back-to-back frames with no dead cycle
        send_bits(8'h5A, 0, 1'b1, 1'b0);
        send_bits(8'hC3, 0, 1'b0, 1'b0);
        settle();
        cmp("b2b_out", int'(out), 'hC3);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
